seq_addsub: RTL and testbench

- Parametrised, multi-cycle successor to the team's 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, using one CHUNK-bit ripple slice reused across cycles.
- Registered start/busy/done handshake, carry-out and signed-overflow flags.
- Sits behind the board top: switches and keys supply operands and start; results drive the LEDs.

---
 rtl/seq_addsub_pkg.sv | 20 ++
 rtl/seq_addsub_chunk_rca.sv | 25 ++
 rtl/seq_addsub.sv | 156 +++++++++++++++
 tb/tb_seq_addsub.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_addsub_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder/subtractor.
package seq_addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk design still needs a 1-bit counter so the port widths stay legal.
  function automatic int calc_cnt_w(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_addsub_chunk_rca.sv
// CHUNK-bit combinational ripple-carry slice, one full-adder cell per bit.
module chunk_rca #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             Cin,
  output logic [CHUNK-1:0] S,
  output logic             Cout
);

  logic [CHUNK:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    logic p;
    assign p        = A[i] ^ B[i];
    assign S[i]     = p ^ c[i];
    assign c[i + 1] = (A[i] & B[i]) | (p & c[i]);
  end

  assign Cout = c[CHUNK];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one CHUNK-bit ripple slice,
// consuming operands LSB-first and assembling the result from the MSB side.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovfl
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = calc_cnt_w(WIDTH, CHUNK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             cout_q, cout_d;
  logic             ovfl_q, ovfl_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] op_a_next;
  logic [WIDTH-1:0] op_b_next;
  logic             unused_acc;

  chunk_rca #(
    .CHUNK(CHUNK)
  ) u_slice (
    .A   (op_a_q[CHUNK-1:0]),
    .B   (op_b_q[CHUNK-1:0]),
    .Cin (carry_q),
    .S   (slice_sum),
    .Cout(slice_cout)
  );

  // With a single chunk there is nothing to shift; the slice result is the answer.
  if (CHUNK == WIDTH) begin : g_single
    assign acc_next   = slice_sum;
    assign op_a_next  = '0;
    assign op_b_next  = '0;
    assign unused_acc = ^acc_q;
  end else begin : g_multi
    assign acc_next   = {slice_sum, acc_q[WIDTH-1:CHUNK]};
    assign op_a_next  = {{CHUNK{1'b0}}, op_a_q[WIDTH-1:CHUNK]};
    assign op_b_next  = {{CHUNK{1'b0}}, op_b_q[WIDTH-1:CHUNK]};
    assign unused_acc = ^acc_q[CHUNK-1:0];
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cout_d  = cout_q;
    ovfl_d  = ovfl_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d  = A;
          op_b_d  = sub ? ~B : B;
          carry_d = sub;
          cnt_d   = '0;
          acc_d   = '0;
          a_msb_d = A[WIDTH-1];
          b_msb_d = sub ? ~B[WIDTH-1] : B[WIDTH-1];
          state_d = CALC;
        end
      end
      CALC: begin
        op_a_d  = op_a_next;
        op_b_d  = op_b_next;
        acc_d   = acc_next;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        // Sign bits were captured at start because the operand registers shift away.
        if (cnt_q == LAST) begin
          s_d     = acc_next;
          cout_d  = slice_cout;
          ovfl_d  = (a_msb_q == b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovfl_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cout_q  <= cout_d;
      ovfl_q  <= ovfl_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;
  assign ovfl = ovfl_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench driving CHUNK = 1, 4 and 16 instances of seq_addsub in parallel
// from one stimulus stream, each checked against an arithmetic reference model.
module tb_seq_addsub;

  localparam int W     = 16;
  localparam int NINST = 3;

  function automatic int chunk_of(input int g);
    case (g)
      0:       return 1;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             sub   = 1'b0;
  logic [W-1:0]     a_in  = '0;
  logic [W-1:0]     b_in  = '0;
  logic [NINST-1:0] busy_w, done_w, cout_w, ovfl_w;
  logic [W-1:0]     s_w [NINST];

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    seq_addsub #(
      .WIDTH(W),
      .CHUNK(chunk_of(g))
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .sub  (sub),
      .A    (a_in),
      .B    (b_in),
      .busy (busy_w[g]),
      .done (done_w[g]),
      .S    (s_w[g]),
      .Cout (cout_w[g]),
      .ovfl (ovfl_w[g])
    );
  end

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    longint       due;
  } exp_t;

  exp_t         sb [NINST][$];
  longint       free_edge [NINST];
  logic [W-1:0] last_s [NINST];
  logic         last_c [NINST];
  logic         last_v [NINST];
  longint       cyc      = 0;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands, no knowledge of chunking.
  function automatic exp_t refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic s_mode, input longint due);
    exp_t   e;
    longint ua, ub, full, sr;
    int     sa, sbv;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (!s_mode) begin
      full = ua + ub;
      e.c  = (full >= 65536);
      sr   = longint'(sa) + longint'(sbv);
    end else begin
      full = ua - ub;
      e.c  = (ua >= ub);
      sr   = longint'(sa) - longint'(sbv);
    end
    e.s   = W'(full);
    e.v   = (sr > 32767) || (sr < -32768);
    e.due = due;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s_mode);
    a_in  = a;
    b_in  = b;
    sub   = s_mode;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Asserts reset asynchronously, clears the model and checks outputs before any edge.
  task automatic doReset();
    rst_n = 1'b0;
    for (int i = 0; i < NINST; i++) begin
      sb[i].delete();
      free_edge[i] = -100;
      last_s[i]    = '0;
      last_c[i]    = 1'b0;
      last_v[i]    = 1'b0;
    end
    #1;
    for (int i = 0; i < NINST; i++) begin
      checkOutput($sformatf("reset_busy[c%0d]", chunk_of(i)), 32'(busy_w[i]), 32'd0);
      checkOutput($sformatf("reset_done[c%0d]", chunk_of(i)), 32'(done_w[i]), 32'd0);
      checkOutput($sformatf("reset_S[c%0d]",    chunk_of(i)), 32'(s_w[i]),    32'd0);
      checkOutput($sformatf("reset_Cout[c%0d]", chunk_of(i)), 32'(cout_w[i]), 32'd0);
      checkOutput($sformatf("reset_ovfl[c%0d]", chunk_of(i)), 32'(ovfl_w[i]), 32'd0);
    end
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 60 && !idle; t++) begin
      idle = (busy_w == '0);
      for (int i = 0; i < NINST; i++) if (sb[i].size() != 0) idle = 1'b0;
      if (!idle) tick();
    end
    checkOutput("idle_timeout", 32'(!idle), 32'd0);
  endtask

  function automatic logic [W-1:0] pickOperand();
    logic [W-1:0] corners [4];
    corners[0] = 16'h0000;
    corners[1] = 16'hFFFF;
    corners[2] = 16'h7FFF;
    corners[3] = 16'h8000;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  // Model: an instance accepts start whenever its previous operation has finished.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst_n && start) begin
        for (int i = 0; i < NINST; i++) begin
          if (cyc > free_edge[i]) begin
            sb[i].push_back(refModel(a_in, b_in, sub, cyc + longint'(W / chunk_of(i))));
            free_edge[i] = cyc + longint'(W / chunk_of(i));
          end
        end
      end
    end
  end

  // Monitor: checks handshake timing and held/updated results on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NINST; i++) begin
        bit   exp_done, exp_busy;
        exp_t e;
        exp_done = (sb[i].size() > 0) && (sb[i][0].due == cyc);
        exp_busy = (cyc >= free_edge[i] - longint'(W / chunk_of(i))) && (cyc < free_edge[i]);
        checkOutput($sformatf("busy[c%0d]", chunk_of(i)), 32'(busy_w[i]), 32'(exp_busy));
        checkOutput($sformatf("done[c%0d]", chunk_of(i)), 32'(done_w[i]), 32'(exp_done));
        if (exp_done) begin
          e         = sb[i].pop_front();
          last_s[i] = e.s;
          last_c[i] = e.c;
          last_v[i] = e.v;
        end
        checkOutput($sformatf("S[c%0d]",    chunk_of(i)), 32'(s_w[i]),    32'(last_s[i]));
        checkOutput($sformatf("Cout[c%0d]", chunk_of(i)), 32'(cout_w[i]), 32'(last_c[i]));
        checkOutput($sformatf("ovfl[c%0d]", chunk_of(i)), 32'(ovfl_w[i]), 32'(last_v[i]));
      end
    end
  end

  initial begin
    doReset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] directed add/sub cases");
    applyStimulus(16'h1234, 16'h4321, 1'b0); waitIdle();
    applyStimulus(16'hFFFF, 16'h0001, 1'b0); waitIdle();
    applyStimulus(16'h7FFF, 16'h0001, 1'b0); waitIdle();
    applyStimulus(16'h0005, 16'h0007, 1'b1); waitIdle();
    applyStimulus(16'h8000, 16'h0001, 1'b1); waitIdle();

    $display("[TB] start while busy");
    applyStimulus(16'h0001, 16'h0001, 1'b0);
    tick();
    applyStimulus(16'hAAAA, 16'h0001, 1'b0);
    waitIdle();

    $display("[TB] start held high with changing operands");
    a_in  = 16'h0102;
    b_in  = 16'h0304;
    sub   = 1'b0;
    start = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      a_in = W'($urandom);
      b_in = W'($urandom);
      sub  = 1'($urandom);
    end
    start = 1'b0;
    waitIdle();

    $display("[TB] reset mid-operation");
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    tick();
    tick();
    doReset();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    applyStimulus(16'h4000, 16'h4000, 1'b0);
    waitIdle();

    $display("[TB] random regression");
    for (int n = 0; n < 80; n++) begin
      applyStimulus(pickOperand(), pickOperand(), 1'($urandom));
      repeat ($urandom_range(0, 20)) tick();
    end
    waitIdle();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
